// File: rtl/lmul_unit.sv
// lmul_unit: iterative 32x32->64 shift-add multiplier for the UMULL/SMULL path.
// A request is accepted in IDLE, magnitudes are multiplied one multiplier bit
// per cycle, the sign is applied in a single FIX cycle, and the product is
// presented with a one-cycle done pulse and held until the next request.
module lmul_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        n_flag,
  output logic        z_flag
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [63:0] acc_fix;
  logic [4:0]  cnt;
  logic        sign;

  // Magnitude of an operand; 0x80000000 maps onto itself, which as an
  // unsigned value is exactly 2^31, so no extra bit is needed.
  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
    logic signed [31:0] neg;
    neg = -v;
    return (sgn && v[31]) ? 32'(neg) : 32'(v);
  endfunction

  // 64-bit two's-complement negation used when the product sign is negative.
  function automatic logic [63:0] neg64(input logic signed [63:0] v);
    logic signed [63:0] neg;
    neg = -v;
    return 64'(neg);
  endfunction

  // Signed-corrected accumulator value committed during FIX.
  always_comb begin
    acc_fix = acc;
    if (sign) acc_fix = neg64(acc);
  end

  assign result_lo = acc[31:0];
  assign result_hi = acc[63:32];

  // Control FSM with the shift-add datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      n_flag <= 1'b0;
      z_flag <= 1'b0;
      acc    <= 64'd0;
      cnt    <= 5'd0;
      sign   <= 1'b0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= mag32(a, is_signed);
            mplier <= mag32(b, is_signed);
            sign   <= is_signed & (a[31] ^ b[31]);
            acc    <= 64'd0;
            cnt    <= 5'd0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[cnt]) acc <= acc + ({32'd0, mcand} << cnt);
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          acc    <= acc_fix;
          n_flag <= acc_fix[63];
          z_flag <= (acc_fix == 64'd0);
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lmul_unit.md
# lmul_unit

Iterative 32x32->64 long-multiply unit serving the multicycle controller's long-multiply path (UMULL/SMULL). The controller drives start/operands from the execute state and consumes the 64-bit product in its two-part writeback (low word, then high word under lmulFlag). The unit is the responder side of that exchange: it accepts a request, computes by shift-add over a fixed number of cycles, signals done, and holds the result until the next accepted request.

## Interface
- No parameters; widths fixed at 32-bit operands and 64-bit product.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; forces IDLE and clears all outputs.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands (SMULL), 0 = unsigned (UMULL); captured with start.
- a  input  32  multiplicand; captured with start.
- b  input  32  multiplier; captured with start.
- busy  output  1  high in CALC and FIX.
- done  output  1  one-cycle pulse in DONE; result valid.
- result_lo  output  32  product bits [31:0].
- result_hi  output  32  product bits [63:32].
- n_flag  output  1  product bit 63 (valid from done).
- z_flag  output  1  1 when the full 64-bit product is zero (valid from done).

## Operation
- States: IDLE, CALC, FIX, DONE. Reset -> IDLE.
- IDLE: start=1 -> capture operands, go CALC, bit counter = 0. start=0 -> stay.
- Capture: magnitude |a|, |b| as 32-bit unsigned when is_signed=1 (0x80000000 stays 0x80000000 = 2^31); raw values when is_signed=0. Store result sign = a[31]^b[31] if signed, else 0. Clear 64-bit accumulator.
- CALC: one multiplier bit per cycle, LSB first; if bit set, add multiplicand shifted by counter into 64-bit accumulator (or equivalent shift-right accumulator form). Counter 0..31; after counter=31 go FIX. No overflow possible: magnitude product < 2^64.
- FIX: always one cycle regardless of is_signed (fixed latency). If sign=1, accumulator <= two's-complement negation (64-bit). Go DONE.
- DONE: done=1, result_lo/hi, n_flag, z_flag reflect final product. Next state IDLE unconditionally; start in DONE is ignored.
- Outputs result_lo/hi/n_flag/z_flag hold the last completed product through IDLE until a new start is accepted; they may change freely during CALC/FIX (controller must only sample on/after done).
- start while busy or in DONE: ignored, no effect on the running operation.
- Operand inputs changing after capture: no effect.

## Timing
- Reset values: busy=0, done=0, result_lo=0, result_hi=0, n_flag=0, z_flag=0, state IDLE.
- start high in IDLE during cycle T -> CALC in cycles T+1..T+32 -> FIX in T+33 -> DONE (done=1) in T+34 -> IDLE in T+35; earliest next accept in T+35.
- Latency start-to-done: 34 cycles, independent of operand values and signedness.
- busy=1 exactly cycles T+1..T+33.
- reset asserted at any cycle (including mid-CALC): next cycle in IDLE with all outputs at reset values; no done pulse for the aborted request.
- reset and start asserted together: reset wins; request dropped.

## Test plan
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF, is_signed=0 -> done at T+34, result_hi=0xFFFFFFFE, result_lo=0x00000001, n_flag=1, z_flag=0.
- Signed -2 (0xFFFFFFFE) x 3 -> result 0xFFFFFFFF_FFFFFFFA, n_flag=1; signed -1 x -1 -> 0x00000000_00000001, n_flag=0.
- Signed 0x80000000 x 0x80000000 -> 0x40000000_00000000; unsigned same operands -> 0x40000000_00000000; signed 0x80000000 x 1 -> 0xFFFFFFFF_80000000.
- 0 x 0x12345678 (both modes) -> result 0, z_flag=1, n_flag=0; verify done exactly one cycle and results held through 10 idle cycles.
- Start pulsed at T+5 and T+20 with different operands while busy, and in DONE cycle -> ignored; single done at T+34 with original product; busy pattern exactly T+1..T+33.
- Reset asserted at T+15 mid-CALC -> all outputs 0 at T+16, no done; new start at T+17 completes with done at T+51 and correct product.
